alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational ALU control path.
- Decodes main-control aluop plus {funct7[5], funct3} and executes the selected operation.
- Single-cycle RV32I ops take one cycle; MUL (M extension, low XLEN bits) runs on an iterative shift-add engine.
- Sits in the EX stage between operand muxes and EX/MEM register; valid/ready on input and output so the pipeline can stall on multiply.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64
- SHW, $clog2(XLEN), shift-amount width taken from b_i[SHW-1:0]

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- in_valid_i  input  1  operation request
- in_ready_o  output  1  block can accept a request this cycle
- ctrl_aluop_i  input  2  00 load/store add, 01 branch compare, 10 R/I-type via funct_i, 11 M-extension
- funct_i  input  4  {funct7[5], funct3}
- a_i  input  XLEN  operand A
- b_i  input  XLEN  operand B
- out_valid_o  output  1  result_o/zero_o/illegal_o valid
- out_ready_i  input  1  consumer takes result
- result_o  output  XLEN  registered result
- zero_o  output  1  result_o == 0 (registered with result)
- illegal_o  output  1  unsupported aluop/funct combination
- busy_o  output  1  multiply in progress

Behaviour:
- Reset: state IDLE; out_valid_o=0, result_o=0, zero_o=1, illegal_o=0, busy_o=0, counter=0. Reset mid-multiply aborts and discards the operation.
- Decode:
  - aluop 00 -> ADD.
  - aluop 01 -> SUB; zero_o is the beq flag.
  - aluop 10 -> funct_i: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND. Any other code (1001,1010,1011,1100,1110,1111) is illegal.
  - aluop 11 -> funct_i[2:0]==000 is MUL; all else illegal.
  - Illegal ops complete in one cycle with result_o=0 and illegal_o=1.
- Arithmetic: all results truncated mod 2^XLEN; shifts use b_i[SHW-1:0] only; SLT/SLTU produce 0 or 1 zero-extended.
- Handshake:
  - in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
  - A request is accepted on a clock edge where in_valid_i && in_ready_o.
  - out_valid_o stays high and outputs stay stable until an edge with out_ready_i=1.
  - Accept and output consume on the same edge is allowed; the new result replaces the old one, with no bubble for single-cycle ops.
  - No-accept edge with out_ready_i=1 clears out_valid_o.
- Single-cycle ops: outputs loaded on the accept edge; latency 1 edge.
- Multiply FSM:
  - IDLE -> MUL on accept: mcand=a_i, mplier=b_i, acc=0, cnt=0, busy_o=1.
  - MUL, each edge: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++.
  - On the edge where cnt==XLEN-1, result_o=final acc, out_valid_o=1, busy_o=0, next state IDLE.
  - Latency: XLEN+1 edges from accept to out_valid_o.
  - in_ready_o is 0 throughout MUL.
  - If out_valid_o from a prior op is still unconsumed, it stays held; the entry condition guarantees the output register is free or being freed.

Optional Feature:
- Macro: ALU_MUL_EARLY_EN.
- Defined: MUL also finishes on the first MUL edge where the post-shift mplier==0. Minimum latency is 2 edges (b_i=0 or 1); busy_o drops the same edge. Result is identical to the full iteration.
- Undefined: fixed XLEN+1 edge latency regardless of operands.

Test Plan:
- Reset, then aluop=10 funct=1000 a=5 b=7, out_ready_i=1 -> next edge out_valid_o=1, result_o=0xFFFFFFFE, zero_o=0, illegal_o=0.
- aluop=10 funct=1101 a=0x80000000 b=0x24 -> result_o=0xF8000000; funct=0010 a=0xFFFFFFFF b=1 -> 1; funct=0011 same operands -> 0.
- aluop=11 funct=0000 a=0x0001_2345 b=0x0000_0100, out_ready_i=1 -> in_ready_o=0 and busy_o=1 for 32 edges; out_valid_o=1 on edge 33 with result_o=0x0123_4500. With ALU_MUL_EARLY_EN, valid on edge 10.
- Back-to-back single-cycle ops with out_ready_i=1 -> one result per cycle, no bubbles. Hold out_ready_i=0 for 3 cycles -> result_o stable, in_ready_o=0, no new accept.
- aluop=10 funct=1011 and aluop=11 funct=0100 -> illegal_o=1, result_o=0, zero_o=1, 1-edge latency.
- Assert rst_i at MUL edge 10 -> next edge state IDLE, busy_o=0, out_valid_o=0. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the EX-stage operand muxes and alu_mc.
// The slave modport is the ALU side; the master modport is the pipeline (or bench) side.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [1:0]      ctrl_aluop_i;
  logic [3:0]      funct_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            illegal_o;
  logic            busy_o;

  modport slave (
    input  in_valid_i, ctrl_aluop_i, funct_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, illegal_o, busy_o
  );

  modport master (
    output in_valid_i, ctrl_aluop_i, funct_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o, busy_o
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: EX-stage RV32I ALU plus M-extension MUL; single-cycle ops 1 edge, MUL XLEN+1 edges (shift-add).
// Output register holds until out_ready_i; in_ready_o low while multiplying or while a result is stuck.
// Optional macro ALU_MUL_EARLY_EN: MUL finishes as soon as the remaining multiplier is zero.
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic     clk_i,
  input logic     rst_i,
  alu_mc_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
  } out_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  state_e          state_q;
  out_t            out_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;

  op_e             dec_op;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            in_ready;
  logic            accept;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] mplier_d;
  logic            mul_done;

  always_comb begin
    dec_op = OP_ILL;
    case (bus.ctrl_aluop_i)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (bus.funct_i)
          4'b0000: dec_op = OP_ADD;
          4'b1000: dec_op = OP_SUB;
          4'b0001: dec_op = OP_SLL;
          4'b0010: dec_op = OP_SLT;
          4'b0011: dec_op = OP_SLTU;
          4'b0100: dec_op = OP_XOR;
          4'b0101: dec_op = OP_SRL;
          4'b1101: dec_op = OP_SRA;
          4'b0110: dec_op = OP_OR;
          4'b0111: dec_op = OP_AND;
          default: dec_op = OP_ILL;
        endcase
      end
      default: dec_op = (bus.funct_i[2:0] == 3'b000) ? OP_MUL : OP_ILL;
    endcase
  end

  assign shamt = bus.b_i[SHW-1:0];

  // Illegal and MUL decode to zero here; MUL results come from the accumulator path.
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = bus.a_i + bus.b_i;
      OP_SUB:  alu_res = bus.a_i - bus.b_i;
      OP_SLL:  alu_res = bus.a_i << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.a_i < bus.b_i)};
      OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
      OP_SRL:  alu_res = bus.a_i >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(bus.a_i) >>> shamt);
      OP_OR:   alu_res = bus.a_i | bus.b_i;
      OP_AND:  alu_res = bus.a_i & bus.b_i;
      default: alu_res = '0;
    endcase
  end

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;

  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_d = mplier_q >> 1;

`ifdef ALU_MUL_EARLY_EN
  assign mul_done = (cnt_q == CNT_LAST) || (mplier_d == '0);
`else
  assign mul_done = (cnt_q == CNT_LAST);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      out_q       <= '{result: '0, zero: 1'b1, illegal: 1'b0};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (dec_op == OP_MUL) begin
              state_q     <= S_MUL;
              mcand_q     <= bus.a_i;
              mplier_q    <= bus.b_i;
              acc_q       <= '0;
              cnt_q       <= '0;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              out_q       <= '{result: alu_res, zero: (alu_res == '0),
                               illegal: (dec_op == OP_ILL)};
              out_valid_q <= 1'b1;
            end
          end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          // A result left over from before the multiply may still be draining.
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
          end
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (mul_done) begin
            out_q       <= '{result: acc_d, zero: (acc_d == '0), illegal: 1'b0};
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = out_q.result;
  assign bus.zero_o      = out_q.zero;
  assign bus.illegal_o   = out_q.illegal;
  assign bus.busy_o      = busy_q;

  a_out_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !bus.out_ready_i) |=> (out_valid_q && $stable(out_q)));

  a_mul_no_accept: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == S_MUL) |-> !in_ready);

  a_busy_matches_state: assert property (@(posedge clk_i) disable iff (rst_i)
    busy_q == (state_q == S_MUL));

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: stimulus pushes expected results, a negedge monitor pops on each consume.
module tb_alu_mc;
  localparam int XLEN = 32;

`ifdef ALU_MUL_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(XLEN)) bus ();
  alu_mc #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0h with empty scoreboard", bus.result_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_result",  bus.result_o,  e.res);
        chk("sb_zero",    bus.zero_o,    e.zero);
        chk("sb_illegal", bus.illegal_o, e.ill);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] fn,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] er, input logic el, input logic push,
                       output int waits);
    bus.in_valid_i   = 1'b1;
    bus.ctrl_aluop_i = op;
    bus.funct_i      = fn;
    bus.a_i          = a;
    bus.b_i          = b;
    if (push) exp_q.push_back('{res: er, zero: (er == '0), ill: el});
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.in_ready_o && waits < 100);
    if (!bus.in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready_o stayed %0b for %0d cycles, required 1", bus.in_ready_o, waits);
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  // Single-cycle op: accepted without waiting and valid one edge later.
  task automatic op1(input logic [1:0] op, input logic [3:0] fn,
                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] er, input logic el);
    int w;
    issue(op, fn, a, b, er, el, 1'b1, w);
    chk("accept_no_bubble", w, 1);
    chk("valid_after_1_edge", bus.out_valid_o, 1'b1);
  endtask

  task automatic mul_run(input logic [3:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] er, input int lat);
    int w;
    int k;
    int bad;
    issue(2'b11, fn, a, b, er, 1'b0, 1'b1, w);
    k = 0;
    bad = 0;
    while (!bus.out_valid_o && k < 100) begin
      if (bus.in_ready_o || !bus.busy_o) bad++;
      @(posedge clk);
      #1;
      k++;
    end
    chk("mul_latency_edges", k, lat);
    chk("mul_busy_stall", bad, 0);
    chk("mul_busy_clear", bus.busy_o, 1'b0);
  endtask

  initial begin
    int w;
    bus.in_valid_i   = 1'b0;
    bus.ctrl_aluop_i = 2'b00;
    bus.funct_i      = 4'b0000;
    bus.a_i          = '0;
    bus.b_i          = '0;
    bus.out_ready_i  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_result",    bus.result_o,    32'h0);
    chk("rst_zero",      bus.zero_o,      1'b1);
    chk("rst_illegal",   bus.illegal_o,   1'b0);
    chk("rst_busy",      bus.busy_o,      1'b0);
    rst = 1'b0;
    chk("rst_in_ready",  bus.in_ready_o,  1'b1);

    // Back-to-back single-cycle ops.
    op1(2'b10, 4'b1000, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0);
    op1(2'b10, 4'b1101, 32'h8000_0000, 32'h24,      32'hF800_0000, 1'b0);
    op1(2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1,       32'd1,         1'b0);
    op1(2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0);
    op1(2'b00, 4'b1111, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0);
    op1(2'b01, 4'b0000, 32'd9,        32'd9,        32'd0,         1'b0);
    op1(2'b10, 4'b0001, 32'd1,        32'h21,       32'd2,         1'b0);
    op1(2'b10, 4'b0101, 32'h8000_0000, 32'd4,       32'h0800_0000, 1'b0);
    op1(2'b10, 4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0);
    op1(2'b10, 4'b0110, 32'hF0,       32'h0F,       32'hFF,        1'b0);
    op1(2'b10, 4'b0111, 32'hF0,       32'h3C,       32'h30,        1'b0);
    op1(2'b10, 4'b0000, 32'd3,        32'd4,        32'd7,         1'b0);
    op1(2'b10, 4'b1011, 32'd1,        32'd2,        32'd0,         1'b1);
    op1(2'b11, 4'b0100, 32'd1,        32'd2,        32'd0,         1'b1);

    // Backpressure: hold out_ready_i low for 3 cycles with a request pending.
    op1(2'b00, 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0);
    bus.out_ready_i  = 1'b0;
    bus.in_valid_i   = 1'b1;
    bus.ctrl_aluop_i = 2'b00;
    bus.funct_i      = 4'b0000;
    bus.a_i          = 32'd1;
    bus.b_i          = 32'd1;
    exp_q.push_back('{res: 32'd2, zero: 1'b0, ill: 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid",    bus.out_valid_o, 1'b1);
      chk("stall_result",   bus.result_o,    32'd30);
      chk("stall_in_ready", bus.in_ready_o,  1'b0);
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready_o, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    chk("release_valid", bus.out_valid_o, 1'b1);

    // Multiplies.
    mul_run(4'b0000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, EARLY ? 9 : 32);
    mul_run(4'b0000, 32'd7,         32'd0,         32'd0,         EARLY ? 1 : 32);
    mul_run(4'b1000, 32'd3,         32'd5,         32'd15,        EARLY ? 3 : 32);
    mul_run(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32);

    // Reset at MUL edge 10 (accept edge counted as edge 1) aborts the multiply.
    issue(2'b11, 4'b0000, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, w);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("mid_mul_busy", bus.busy_o, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",      bus.busy_o,      1'b0);
    chk("abort_out_valid", bus.out_valid_o, 1'b0);
    chk("abort_in_ready",  bus.in_ready_o,  1'b1);
    rst = 1'b0;
    op1(2'b00, 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
